// File: rtl/rip_2r1w_bram_ctrl_pkg.sv
// Shared types for the 2R1W BRAM requester controller.
package rip_bram_ctrl_pkg;

  // CLEAR zero-fills the array after reset; RUN serves both channels.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/rip_2r1w_bram_ctrl_if.sv
// Pipeline-facing request/response channels of the BRAM controller.
// Channel A is read/write (BRAM port 1), channel B is read-only (BRAM port 2).
interface rip_2r1w_bram_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  a_req_valid;
  logic                  a_req_ready;
  logic                  a_req_we;
  logic [ADDR_WIDTH-1:0] a_req_addr;
  logic [DATA_WIDTH-1:0] a_req_wdata;
  logic                  a_rsp_valid;
  logic                  a_rsp_ready;
  logic [DATA_WIDTH-1:0] a_rsp_rdata;

  logic                  b_req_valid;
  logic                  b_req_ready;
  logic [ADDR_WIDTH-1:0] b_req_addr;
  logic                  b_rsp_valid;
  logic                  b_rsp_ready;
  logic [DATA_WIDTH-1:0] b_rsp_rdata;

  // Pipeline side.
  modport master (
    output a_req_valid, a_req_we, a_req_addr, a_req_wdata, a_rsp_ready,
    output b_req_valid, b_req_addr, b_rsp_ready,
    input  a_req_ready, a_rsp_valid, a_rsp_rdata,
    input  b_req_ready, b_rsp_valid, b_rsp_rdata
  );

  // Controller side.
  modport slave (
    input  a_req_valid, a_req_we, a_req_addr, a_req_wdata, a_rsp_ready,
    input  b_req_valid, b_req_addr, b_rsp_ready,
    output a_req_ready, a_rsp_valid, a_rsp_rdata,
    output b_req_ready, b_rsp_valid, b_rsp_rdata
  );
endinterface

// File: rtl/rip_2r1w_bram_ctrl_rsp_slot.sv
// One-entry response slot for a single BRAM port. The BRAM output register
// is the only storage: while a response is stalled the port enable is held
// low so the BRAM keeps driving the same dout.
module rip_bram_rsp_slot
  import rip_bram_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic req_valid,
  input  logic rsp_ready,
  output logic req_ready,
  output logic bram_enable,
  output logic rsp_valid
);

  assign req_ready   = run && (!rsp_valid || rsp_ready);
  assign bram_enable = req_valid && req_ready;

  // Response becomes valid one cycle after accept, drops once consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
    end else if (bram_enable) begin
      rsp_valid <= 1'b1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rip_2r1w_bram_ctrl.sv
// Requester-side controller for the 2-read/1-write block RAM.
// Clears the whole array after reset, then serves channel A (port 1, r/w,
// read-first) and channel B (port 2, read-only) with 1-cycle latency.
// Optional macro RIP_BRAM_CTRL_FWD_EN: forwards same-cycle A write data
// to a colliding B read.
module rip_2r1w_bram_ctrl
  import rip_bram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  rip_2r1w_bram_ctrl_if.slave   bus,
  output logic                  init_done,
  output logic                  bram_we_1,
  output logic                  bram_enable_1,
  output logic                  bram_enable_2,
  output logic [ADDR_WIDTH-1:0] bram_addr_1,
  output logic [ADDR_WIDTH-1:0] bram_addr_2,
  output logic [DATA_WIDTH-1:0] bram_din_1,
  input  logic [DATA_WIDTH-1:0] bram_dout_1,
  input  logic [DATA_WIDTH-1:0] bram_dout_2
);

  ctrl_state_e         state;
  logic [ADDR_WIDTH:0] clr_cnt;
  logic [ADDR_WIDTH:0] clr_nxt;
  logic                run;
  logic                clearing;
  logic                a_en;
  logic                b_en;

  assign clr_nxt  = clr_cnt + (ADDR_WIDTH+1)'(1);
  assign run      = (state == RUN) && !rst;
  assign clearing = (state == CLEAR) && !rst;

  // Clear sequencer: counter MSB set after the last address marks completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_nxt;
          if (clr_nxt[ADDR_WIDTH]) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  rip_bram_rsp_slot u_slot_a (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .req_valid   (bus.a_req_valid),
    .rsp_ready   (bus.a_rsp_ready),
    .req_ready   (bus.a_req_ready),
    .bram_enable (a_en),
    .rsp_valid   (bus.a_rsp_valid)
  );

  rip_bram_rsp_slot u_slot_b (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .req_valid   (bus.b_req_valid),
    .rsp_ready   (bus.b_rsp_ready),
    .req_ready   (bus.b_req_ready),
    .bram_enable (b_en),
    .rsp_valid   (bus.b_rsp_valid)
  );

  // Port 1 is owned by the clear sequencer until RUN, then by channel A.
  always_comb begin
    bram_enable_1 = clearing || a_en;
    bram_we_1     = clearing || (a_en && bus.a_req_we);
    bram_addr_1   = clearing ? clr_cnt[ADDR_WIDTH-1:0] : bus.a_req_addr;
    bram_din_1    = clearing ? '0 : bus.a_req_wdata;
  end

  assign bram_enable_2   = b_en;
  assign bram_addr_2     = bus.b_req_addr;
  assign bus.a_rsp_rdata = bram_dout_1;

`ifdef RIP_BRAM_CTRL_FWD_EN
  logic                  fwd_hit;
  logic                  fwd_q;
  logic [DATA_WIDTH-1:0] fwd_data;

  assign fwd_hit = a_en && bus.a_req_we && b_en && (bus.a_req_addr == bus.b_req_addr);

  // Forward flag tracks the B response it belongs to: set on accept, held
  // while stalled, dropped on consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_q <= 1'b0;
    end else if (b_en) begin
      fwd_q <= fwd_hit;
      if (fwd_hit) begin
        fwd_data <= bus.a_req_wdata;
      end
    end else if (bus.b_rsp_ready) begin
      fwd_q <= 1'b0;
    end
  end

  assign bus.b_rsp_rdata = fwd_q ? fwd_data : bram_dout_2;
`else
  assign bus.b_rsp_rdata = bram_dout_2;
`endif

endmodule

// File: doc/rip_2r1w_bram_ctrl.md
Name: rip_2r1w_bram_ctrl

Overview:
Requester-side controller that drives the ports of the team's 2-read/1-write block RAM (port 1 read/write, port 2 read-only, 1-cycle registered read). It exposes two valid/ready request/response channels to the pipeline: channel A (read/write) and channel B (read-only). It absorbs the BRAM read latency, applies backpressure by gating the BRAM enables, and zero-fills the whole array after reset.

Parameters:
DATA_WIDTH, 32, BRAM word width
ADDR_WIDTH, 10, BRAM address width; depth = 2**ADDR_WIDTH

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
a_req_valid  in  1  channel A request valid
a_req_ready  out  1  channel A request accepted
a_req_we  in  1  1 = write, 0 = read
a_req_addr  in  ADDR_WIDTH  channel A address
a_req_wdata  in  DATA_WIDTH  channel A write data
a_rsp_valid  out  1  channel A response valid
a_rsp_ready  in  1  channel A response consumed
a_rsp_rdata  out  DATA_WIDTH  read data; for writes, the pre-write (old) word
b_req_valid  in  1  channel B request valid
b_req_ready  out  1  channel B request accepted
b_req_addr  in  ADDR_WIDTH  channel B address
b_rsp_valid  out  1  channel B response valid
b_rsp_ready  in  1  channel B response consumed
b_rsp_rdata  out  DATA_WIDTH  channel B read data
init_done  out  1  high once post-reset clear is complete
bram_we_1  out  1  BRAM port 1 write enable
bram_enable_1  out  1  BRAM port 1 enable
bram_enable_2  out  1  BRAM port 2 enable
bram_addr_1  out  ADDR_WIDTH  BRAM port 1 address
bram_addr_2  out  ADDR_WIDTH  BRAM port 2 address
bram_din_1  out  DATA_WIDTH  BRAM port 1 write data
bram_dout_1  in  DATA_WIDTH  BRAM port 1 read data (valid 1 cycle after enable)
bram_dout_2  in  DATA_WIDTH  BRAM port 2 read data

Behaviour:
- Clock is clk. Reset rst is synchronous and active-high.
- Reset values: state = CLEAR, clear counter = 0, a_rsp_valid = b_rsp_valid = 0, init_done = 0, a_req_ready = b_req_ready = 0.
- FSM has two states:
  - CLEAR: each cycle drives bram_enable_1 = 1, bram_we_1 = 1, bram_addr_1 = counter, bram_din_1 = 0, then increments the counter. After writing address 2**ADDR_WIDTH-1, it moves to RUN. The clear takes exactly 2**ADDR_WIDTH cycles.
  - In CLEAR, both req_ready outputs are 0 and port 2 is idle.
  - RUN: init_done = 1. RUN is left only on rst.
- Channel X slot is free when !x_rsp_valid || x_rsp_ready.
- x_req_ready = (state == RUN) && slot free. This is combinational, and x_req_ready does not depend on x_req_valid.
- Accept: when x_req_valid && x_req_ready, the controller asserts the BRAM enable for that port with the request address (and for A, we/din) in the same cycle. x_rsp_valid is set the next cycle, so latency is 1 cycle.
- Backpressure:
  - When x_rsp_valid && !x_rsp_ready, the BRAM enable for that port is 0, so the BRAM holds dout. x_rsp_rdata = bram_dout_x stays stable until consumed.
  - No skid buffer is used.
- If x_rsp_ready is high with no new accept, x_rsp_valid clears the next cycle.
- Back-to-back: accept plus consume in the same cycle gives one response per cycle at full throughput.
- Channel A write response: rdata is the old contents, because the BRAM port is read-first.
- Same-address A write and B read in the same cycle: B returns the old word (default, see FWD_EN).
- A write at cycle t followed by a B read at t+1 or later to the same address: B sees the new data.
- Address wrap: the clear counter is ADDR_WIDTH+1 bits wide, and its MSB marks completion. Request addresses are used unmodified.
- rst asserted mid-operation: pending responses are dropped (rsp_valid = 0 next cycle), the FSM returns to CLEAR, and the array is re-zeroed.
- While rst is high, all bram_* enables are 0.

Optional Feature:
Macro RIP_BRAM_CTRL_FWD_EN.
- Defined: when A accepts a write and B accepts a read to the same address in the same cycle, the controller registers a forward flag and a_req_wdata. b_rsp_rdata then returns the forwarded data in place of bram_dout_2. The flag is held while b_rsp is stalled and cleared on consume or rst.
- Undefined: no forwarding logic; B returns the old word.

Decomposition:
- Package rip_bram_ctrl_pkg holds the state enum (CLEAR, RUN).
- Natural sub-module: rip_bram_rsp_slot, instantiated twice (A, B). It owns rsp_valid, slot-free/ready, and the enable-gating logic for one port.
- The FSM, clear counter and forwarding logic stay in the top module.

Test Plan:
- Reset, then idle → init_done rises exactly 1024 cycles after rst deasserts (ADDR_WIDTH = 10). Reads of addresses 0, 511 and 1023 return 0.
- A writes 0xDEADBEEF to 0x05, then B reads 0x05 → B rsp_rdata = 0xDEADBEEF, one cycle after accept. A write rsp_rdata = 0x00000000.
- B read of 0x10 (holding 0x1234), with b_rsp_ready low for 5 cycles → b_rsp_valid stays high, rdata stays 0x1234 throughout, b_req_ready = 0, bram_enable_2 = 0.
- Same cycle: A writes 0xA5A5A5A5 to 0x20 (old value 0x11) and B reads 0x20 → B returns 0x11 without FWD_EN, 0xA5A5A5A5 with RIP_BRAM_CTRL_FWD_EN.
- Streaming: 8 back-to-back A reads with rsp_ready held high → 8 consecutive response cycles, no bubbles.
- rst pulsed while a_rsp_valid = 1 after writes → a_rsp_valid = 0 next cycle, the clear re-runs, and the previously written address reads 0.
